// File: rtl/exec_unit.sv
// exec_unit: execute stage feeding the 8x16 register file write port.
// Latency: ALU ops 1 cycle (strobe in cycle 1); MUL strobe in cycle 17, busy high cycles 1-16.
// Backpressure: start is dropped (not queued) while busy; optional MUL built only with `EXEC_MUL_EN.
// Ports: clk, rst (sync active-low); start/op/dest/src_a/src_b issue side;
//        busy; reg_write_en/reg_write_dest/reg_write_data write-back; flag_zero/flag_carry.
module exec_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [2:0]  dest,
  input  logic [15:0] src_a,
  input  logic [15:0] src_b,
  output logic        busy,
  output logic        reg_write_en,
  output logic [2:0]  reg_write_dest,
  output logic [15:0] reg_write_data,
  output logic        flag_zero,
  output logic        flag_carry
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;

  // Single-cycle ALU result for the currently presented operands.
  logic        alu_wr;
  logic [15:0] alu_data;
  logic        alu_carry;
  logic [3:0]  sh_idx;

  always_comb begin
    alu_wr    = 1'b1;
    alu_data  = 16'h0000;
    alu_carry = 1'b0;
    // 16 - amount, mod 16: index of the last bit pushed out by SHL
    sh_idx    = 4'd0 - src_b[3:0];
    case (op)
      OP_ADD: {alu_carry, alu_data} = {1'b0, src_a} + {1'b0, src_b};
      OP_SUB: begin
        alu_data  = src_a - src_b;
        alu_carry = (src_a < src_b);
      end
      OP_AND: alu_data = src_a & src_b;
      OP_OR:  alu_data = src_a | src_b;
      OP_XOR: alu_data = src_a ^ src_b;
      OP_SHL: begin
        alu_data  = src_a << src_b[3:0];
        alu_carry = (src_b[3:0] != 4'd0) ? src_a[sh_idx] : 1'b0;
      end
      default: alu_wr = 1'b0;  // NOP, and MUL which is handled separately
    endcase
  end

  // Write-back request for the next cycle.
  logic        wb_fire;
  logic [2:0]  wb_dest;
  logic [15:0] wb_data;
  logic        wb_carry;

`ifdef EXEC_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b110;

  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;
  state_t state, state_next;

  logic        issue;
  logic [15:0] a_q, b_q;
  logic [2:0]  dest_q;
  logic [31:0] acc, acc_next;
  logic [3:0]  cnt;

  assign issue = start && (state == IDLE);
  assign busy  = (state == MUL);

  // One shift-add step per cycle, LSB of b first.
  always_comb begin
    acc_next = acc;
    if (b_q[cnt]) acc_next = acc + ({16'h0000, a_q} << cnt);
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (issue && op == OP_MUL) state_next = MUL;
      MUL:     if (cnt == 4'hF) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q    <= 16'h0000;
      b_q    <= 16'h0000;
      dest_q <= 3'd0;
      acc    <= 32'h0;
      cnt    <= 4'd0;
    end else if (issue && op == OP_MUL) begin
      a_q    <= src_a;
      b_q    <= src_b;
      dest_q <= dest;
      acc    <= 32'h0;
      cnt    <= 4'd0;
    end else if (state == MUL) begin
      acc <= acc_next;
      cnt <= cnt + 4'd1;
    end
  end

  always_comb begin
    wb_fire  = issue && alu_wr;
    wb_dest  = dest;
    wb_data  = alu_data;
    wb_carry = alu_carry;
    // Last iteration: write back the product including this step's addend.
    if (state == MUL && cnt == 4'hF) begin
      wb_fire  = 1'b1;
      wb_dest  = dest_q;
      wb_data  = acc_next[15:0];
      wb_carry = |acc_next[31:16];
    end
  end
`else
  assign busy     = 1'b0;
  assign wb_fire  = start && alu_wr;
  assign wb_dest  = dest;
  assign wb_data  = alu_data;
  assign wb_carry = alu_carry;
`endif

  // Write-back port and flags; data, dest and flags hold between strobes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      reg_write_en   <= 1'b0;
      reg_write_dest <= 3'd0;
      reg_write_data <= 16'h0000;
      flag_zero      <= 1'b0;
      flag_carry     <= 1'b0;
    end else begin
      reg_write_en <= wb_fire;
      if (wb_fire) begin
        reg_write_dest <= wb_dest;
        reg_write_data <= wb_data;
        flag_zero      <= (wb_data == 16'h0000);
        flag_carry     <= wb_carry;
      end
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: directed and randomized checks of exec_unit against a behavioural model.
// Model updates on posedge from the sampled inputs; outputs compared on every negedge.
// Directed cases pin the model with literal expectations; MUL cases only when `EXEC_MUL_EN.
module tb_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [2:0]  dest = 3'd0;
  logic [15:0] src_a = 16'h0;
  logic [15:0] src_b = 16'h0;
  logic        busy;
  logic        reg_write_en;
  logic [2:0]  reg_write_dest;
  logic [15:0] reg_write_data;
  logic        flag_zero;
  logic        flag_carry;

  exec_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .dest(dest),
    .src_a(src_a), .src_b(src_b), .busy(busy),
    .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest),
    .reg_write_data(reg_write_data), .flag_zero(flag_zero), .flag_carry(flag_carry)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_busy = 1'b0, m_en = 1'b0, m_zero = 1'b0, m_carry = 1'b0;
  logic [2:0]  m_dest = 3'd0;
  logic [15:0] m_data = 16'h0;
  int          mul_left = 0;
  logic [31:0] mul_prod = 32'h0;
  logic [2:0]  mul_dest = 3'd0;

  task automatic alu_model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                           output bit wr, output logic [15:0] d, output logic c);
    logic [31:0] wide;
    wr = 1'b1; d = 16'h0; c = 1'b0;
    case (o)
      3'd0: begin wide = {16'h0, a} + {16'h0, b}; d = wide[15:0]; c = wide[16]; end
      3'd1: begin d = a - b; c = (a < b); end
      3'd2: d = a & b;
      3'd3: d = a | b;
      3'd4: d = a ^ b;
      3'd5: begin wide = {16'h0, a} << b[3:0]; d = wide[15:0]; c = wide[16]; end
      default: wr = 1'b0;
    endcase
  endtask

  task automatic model_write(input logic [2:0] d, input logic [15:0] v, input logic c);
    m_en = 1'b1; m_dest = d; m_data = v; m_zero = (v == 16'h0); m_carry = c;
  endtask

  always @(posedge clk) begin
    bit          wr;
    logic [15:0] d;
    logic        c;
    if (!rst) begin
      m_busy = 1'b0; m_en = 1'b0; m_dest = 3'd0; m_data = 16'h0;
      m_zero = 1'b0; m_carry = 1'b0; mul_left = 0;
    end else begin
      m_en = 1'b0;
      if (mul_left > 0) begin
        mul_left--;
        if (mul_left == 0) model_write(mul_dest, mul_prod[15:0], |mul_prod[31:16]);
      end else if (start) begin
`ifdef EXEC_MUL_EN
        if (op == 3'b110) begin
          mul_prod = {16'h0, src_a} * {16'h0, src_b};
          mul_dest = dest;
          mul_left = 16;
        end else
`endif
        begin
          alu_model(op, src_a, src_b, wr, d, c);
          if (wr) model_write(dest, d, c);
        end
      end
      m_busy = (mul_left > 0);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", busy, m_busy);
      chk("wr_en", reg_write_en, m_en);
      chk("wr_dest", reg_write_dest, m_dest);
      chk("wr_data", reg_write_data, m_data);
      chk("zero", flag_zero, m_zero);
      chk("carry", flag_carry, m_carry);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input bit s, input logic [2:0] o, input logic [2:0] d,
                       input logic [15:0] a, input logic [15:0] b);
    start = s; op = o; dest = d; src_a = a; src_b = b;
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 4))
      0: rnd16 = 16'h0000;
      1: rnd16 = 16'hFFFF;
      2: rnd16 = 16'($urandom_range(0, 20));
      3: rnd16 = 16'h8000 | 16'($urandom_range(0, 3));
      default: rnd16 = 16'($urandom);
    endcase
  endfunction

  int nb;
  int ns;

  initial begin
    // Reset held two cycles with an ADD request present.
    rst = 1'b0;
    drive(1'b1, 3'b000, 3'd1, 16'h0001, 16'h0001);
    @(posedge clk); @(negedge clk); #1;
    chk_on = 1'b1;
    tick();
    chk("rst_en", reg_write_en, 0);
    chk("rst_data", reg_write_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {flag_zero, flag_carry}, 0);
    rst = 1'b1;
    drive(1'b0, 3'b000, 3'd0, 16'h0, 16'h0);
    tick();
    chk("idle_en", reg_write_en, 0);

    drive(1'b1, 3'b000, 3'd5, 16'hFFFF, 16'h0001);
    tick();
    chk("add_en", reg_write_en, 1);
    chk("add_dest", reg_write_dest, 5);
    chk("add_data", reg_write_data, 16'h0000);
    chk("add_zc", {flag_zero, flag_carry}, 2'b11);

    drive(1'b1, 3'b001, 3'd2, 16'h0003, 16'h0005);
    tick();
    chk("sub_en", reg_write_en, 1);
    chk("sub_data", reg_write_data, 16'hFFFE);
    chk("sub_zc", {flag_zero, flag_carry}, 2'b01);

    drive(1'b1, 3'b101, 3'd1, 16'h8001, 16'h0001);
    tick();
    chk("shl1_data", reg_write_data, 16'h0002);
    chk("shl1_carry", flag_carry, 1);

    drive(1'b1, 3'b101, 3'd1, 16'h1234, 16'h0000);
    tick();
    chk("shl0_data", reg_write_data, 16'h1234);
    chk("shl0_carry", flag_carry, 0);

    drive(1'b0, 3'b000, 3'd0, 16'h0, 16'h0);
    tick();
    chk("hold_en", reg_write_en, 0);
    chk("hold_data", reg_write_data, 16'h1234);

`ifdef EXEC_MUL_EN
    // MUL 0x0123 * 0x0010, then an ADD in the strobe cycle.
    drive(1'b1, 3'b110, 3'd3, 16'h0123, 16'h0010);
    tick();
    drive(1'b0, 3'b000, 3'd0, 16'h0, 16'h0);
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy !== 1'b1) break;
      nb++;
      tick();
    end
    chk("mul1_busy_cycles", nb, 16);
    chk("mul1_en", reg_write_en, 1);
    chk("mul1_dest", reg_write_dest, 3);
    chk("mul1_data", reg_write_data, 16'h1230);
    chk("mul1_zc", {flag_zero, flag_carry}, 2'b00);
    drive(1'b1, 3'b000, 3'd7, 16'h0002, 16'h0003);
    tick();
    chk("after_mul_add_data", reg_write_data, 16'h0005);
    chk("after_mul_add_dest", reg_write_dest, 7);

    // MUL 0x8000 * 0x0004 with a start pulse while busy.
    drive(1'b1, 3'b110, 3'd4, 16'h8000, 16'h0004);
    tick();
    nb = 0; ns = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 4) drive(1'b1, 3'b000, 3'd6, 16'h0001, 16'h0001);
      else        drive(1'b0, 3'b000, 3'd0, 16'h0, 16'h0);
      if (busy !== 1'b1) break;
      nb++;
      if (reg_write_en === 1'b1) ns++;
      tick();
    end
    chk("mul2_busy_cycles", nb, 16);
    chk("mul2_early_strobes", ns, 0);
    chk("mul2_en", reg_write_en, 1);
    chk("mul2_data", reg_write_data, 16'h0000);
    chk("mul2_zc", {flag_zero, flag_carry}, 2'b11);
    tick();
    chk("mul2_single_strobe", reg_write_en, 0);

    // Reset in cycle 8 of a MUL aborts it.
    drive(1'b1, 3'b110, 3'd2, 16'hFFFF, 16'hFFFF);
    tick();
    drive(1'b0, 3'b000, 3'd0, 16'h0, 16'h0);
    repeat (7) tick();
    chk("abort_busy_before", busy, 1);
    rst = 1'b0;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_en", reg_write_en, 0);
    rst = 1'b1;
    ns = 0;
    repeat (20) begin
      tick();
      if (reg_write_en !== 1'b0) ns++;
    end
    chk("abort_no_strobe", ns, 0);
    chk("abort_data", reg_write_data, 16'h0000);
`else
    drive(1'b1, 3'b000, 3'd5, 16'hFFFF, 16'h0001);
    tick();
    drive(1'b1, 3'b110, 3'd2, 16'h0003, 16'h0004);
    tick();
    chk("op110_en", reg_write_en, 0);
    chk("op110_busy", busy, 0);
    chk("op110_flags", {flag_zero, flag_carry}, 2'b11);
    chk("op110_dest", reg_write_dest, 5);
    drive(1'b1, 3'b111, 3'd3, 16'h0007, 16'h0001);
    tick();
    chk("nop_en", reg_write_en, 0);
    chk("nop_busy", busy, 0);
    chk("nop_flags", {flag_zero, flag_carry}, 2'b11);
`endif

    // Randomized traffic, checked every cycle by the compare process.
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 99) != 0);
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            rnd16(), rnd16());
      tick();
    end

    rst = 1'b1;
    drive(1'b0, 3'b111, 3'd0, 16'h0, 16'h0);
    tick();
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
